// File: rtl/led_blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_scheduler
// Purpose  : Round-robin time-sharing of one LED among NUM_REQ blink-burst
//            requesters, with ON/OFF/GAP phases timed in prescaler ticks.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int COUNT_W    = 4,
    parameter int PRESCALE_W = 22,
    parameter int ON_TICKS   = 2,
    parameter int OFF_TICKS  = 2,
    parameter int GAP_TICKS  = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COUNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       tick,
    output logic                       led
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int MAX_T = (ON_TICKS > OFF_TICKS)
                         ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                         : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int PH_W  = (MAX_T <= 1) ? 1 : $clog2(MAX_T);

    localparam logic [PH_W-1:0]  ON_LAST   = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]  OFF_LAST  = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NREQ_W    = (IDX_W+1)'(NUM_REQ);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ON   = 3'd1;
    localparam logic [2:0] S_OFF  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_SKIP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [COUNT_W-1:0]    remaining_q, remaining_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;

    logic                  w_found;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W:0]        w_cand;
    logic [COUNT_W-1:0]    w_sel_count;
    logic [NUM_REQ-1:0]    w_sel_onehot;

    assign tick        = &prescaler_q;
    assign grant       = grant_q;
    assign prescaler_d = prescaler_q + PRESCALE_W'(1);

    // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (w_cand >= NREQ_W) begin
                w_cand = w_cand - NREQ_W;
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_sel_count  = req_count[w_sel*COUNT_W +: COUNT_W];
    assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            phase_q     <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        case (state_q)
            S_IDLE: begin
                // A tick coincident with the grant edge is deliberately ignored.
                grant_d = '0;
                phase_d = '0;
                if (w_found) begin
                    grant_d     = w_sel_onehot;
                    idx_d       = w_sel;
                    remaining_d = w_sel_count;
                    state_d     = (w_sel_count == '0) ? S_SKIP : S_ON;
                end
            end
            S_ON: begin
                if (tick) begin
                    if (phase_q == ON_LAST) begin
                        phase_d = '0;
                        state_d = S_OFF;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            S_OFF: begin
                if (tick) begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = '0;
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - COUNT_W'(1);
                        end
                        state_d = (remaining_q <= COUNT_W'(1)) ? S_GAP : S_ON;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (phase_q == GAP_LAST) begin
                        phase_d = '0;
                        state_d = S_DONE;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            S_SKIP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        led  = (state_q == S_ON);
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE) ? grant_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_led_blink_scheduler
// Purpose  : Directed self-checking bench for led_blink_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_scheduler;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_count;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        tick;
    logic        led;

    int n_cmp;
    int n_bad;
    int cyc;

    led_blink_scheduler #(
        .NUM_REQ    (4),
        .COUNT_W    (4),
        .PRESCALE_W (2),
        .ON_TICKS   (1),
        .OFF_TICKS  (1),
        .GAP_TICKS  (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_count (req_count),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .tick      (tick),
        .led       (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #2;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req       = '0;
        req_count = '0;
        repeat (3) step();
        n_cmp++;
        if (led !== 1'b0 || busy !== 1'b0 || tick !== 1'b0 || grant !== 4'b0 || done !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: led=%b busy=%b tick=%b grant=%b done=%b, required all 0",
                     led, busy, tick, grant, done);
        end
        reset_n = 1'b1;
        cyc     = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            n_cmp++;
            if (tick !== (n % 4 == 3)) begin
                n_bad++;
                $display("FAIL idle_tick cycle %0d: tick=%b, required %b", n, tick, (n % 4 == 3));
            end
            n_cmp++;
            if (led !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_quiet cycle %0d: led=%b busy=%b, required 0 0", n, led, busy);
            end
        end
    endtask

    task automatic test_single_burst();
        logic       e_led;
        logic [3:0] e_grant;
        logic [3:0] e_done;
        logic       e_busy;
        while (cyc % 4 != 3) step();
        req_count[3:0] = 4'd2;
        req            = 4'b0001;
        for (int o = 0; o < 26; o++) begin
            step();
            if (o == 0) req = '0;
            e_led   = (o < 16) && ((o / 4) % 2 == 0);
            e_grant = (o <= 24) ? 4'b0001 : 4'b0000;
            e_done  = (o == 24) ? 4'b0001 : 4'b0000;
            e_busy  = (o <= 24);
            n_cmp++;
            if (led !== e_led) begin
                n_bad++;
                $display("FAIL burst_led offset %0d: led=%b, required %b", o, led, e_led);
            end
            n_cmp++;
            if (grant !== e_grant) begin
                n_bad++;
                $display("FAIL burst_grant offset %0d: grant=%b, required %b", o, grant, e_grant);
            end
            n_cmp++;
            if (done !== e_done) begin
                n_bad++;
                $display("FAIL burst_done offset %0d: done=%b, required %b", o, done, e_done);
            end
            n_cmp++;
            if (busy !== e_busy) begin
                n_bad++;
                $display("FAIL burst_busy offset %0d: busy=%b, required %b", o, busy, e_busy);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        logic [3:0] g_next;
        int         cnt;
        int         w;
        bit         seen;
        reset_n         = 1'b0;
        req_count       = '0;
        req_count[3:0]  = 4'd1;
        req_count[11:8] = 4'd1;
        req             = 4'b0101;
        repeat (2) step();
        reset_n = 1'b1;
        cyc     = 0;
        step();
        n_cmp++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_first_grant: grant=%b busy=%b, required 0001 1", grant, busy);
        end
        for (int b = 0; b < 4; b++) begin
            g      = (b % 2 == 0) ? 4'b0001 : 4'b0100;
            g_next = (b % 2 == 0) ? 4'b0100 : 4'b0001;
            cnt    = int'(led);
            seen   = 1'b0;
            w      = 0;
            while (!seen && w < 40) begin
                step();
                w++;
                cnt += int'(led);
                if (done !== 4'b0) seen = 1'b1;
            end
            n_cmp++;
            if (!seen) begin
                n_bad++;
                $display("FAIL rr_done_timeout burst %0d: no done in 40 cycles, required done=%b", b, g);
            end
            n_cmp++;
            if (done !== g || grant !== g) begin
                n_bad++;
                $display("FAIL rr_order burst %0d: done=%b grant=%b, required %b %b", b, done, grant, g, g);
            end
            n_cmp++;
            if ((b == 0 && cnt != 3) || (b != 0 && (cnt < 1 || cnt > 4))) begin
                n_bad++;
                $display("FAIL rr_partial_on burst %0d: led high %0d cycles, required %s",
                         b, cnt, (b == 0) ? "3" : "1..4");
            end
            step();
            if (b == 3) req = '0;
            n_cmp++;
            if (busy !== 1'b0 || grant !== 4'b0 || done !== 4'b0) begin
                n_bad++;
                $display("FAIL rr_idle_gap burst %0d: busy=%b grant=%b done=%b, required 0 0000 0000",
                         b, busy, grant, done);
            end
            if (b < 3) begin
                step();
                n_cmp++;
                if (grant !== g_next || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rr_next_grant burst %0d: grant=%b busy=%b, required %b 1",
                             b, grant, busy, g_next);
                end
            end
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_release: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_zero_count();
        req_count = '0;
        req       = 4'b1000;
        step();
        req = '0;
        n_cmp++;
        if (grant !== 4'b1000 || done !== 4'b0 || led !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_first: grant=%b done=%b led=%b busy=%b, required 1000 0000 0 1",
                     grant, done, led, busy);
        end
        step();
        n_cmp++;
        if (grant !== 4'b1000 || done !== 4'b1000 || led !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done: grant=%b done=%b led=%b, required 1000 1000 0", grant, done, led);
        end
        step();
        n_cmp++;
        if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_release: grant=%b done=%b busy=%b, required 0000 0000 0", grant, done, busy);
        end
    endtask

    task automatic test_drop_req();
        int   rises;
        logic prev;
        bit   seen;
        int   w;
        req_count[7:4] = 4'd3;
        req            = 4'b0010;
        step();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL drop_grant: grant=%b, required 0010", grant);
        end
        rises = (led === 1'b1) ? 1 : 0;
        prev  = led;
        step();
        req = '0;
        if (led === 1'b1 && prev !== 1'b1) rises++;
        prev = led;
        seen = 1'b0;
        w    = 0;
        while (!seen && w < 80) begin
            step();
            w++;
            if (led === 1'b1 && prev !== 1'b1) rises++;
            prev = led;
            if (done !== 4'b0) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || done !== 4'b0010) begin
            n_bad++;
            $display("FAIL drop_done: done=%b seen=%0d, required 0010 1", done, seen);
        end
        n_cmp++;
        if (rises != 3) begin
            n_bad++;
            $display("FAIL drop_blinks: %0d blinks, required 3", rises);
        end
        step();
        n_cmp++;
        if (done !== 4'b0 || grant !== 4'b0) begin
            n_bad++;
            $display("FAIL drop_release: done=%b grant=%b, required 0000 0000", done, grant);
        end
    endtask

    task automatic test_async_reset();
        while (cyc % 4 != 3) step();
        req_count[7:4] = 4'd2;
        req            = 4'b0010;
        step();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL areset_grant: grant=%b, required 0010", grant);
        end
        step();
        n_cmp++;
        if (led !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_on: led=%b, required 1", led);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (led !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
            n_bad++;
            $display("FAIL areset_immediate: led=%b grant=%b busy=%b done=%b, required 0 0000 0 0000",
                     led, grant, busy, done);
        end
        req            = 4'b0011;
        req_count[3:0] = 4'd1;
        step();
        step();
        n_cmp++;
        if (done !== 4'b0 || led !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_hold: done=%b led=%b, required 0000 0", done, led);
        end
        reset_n = 1'b1;
        cyc     = 0;
        step();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL areset_pointer: grant=%b, required 0001", grant);
        end
        req = '0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        req       = '0;
        req_count = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_zero_count();
        test_drop_req();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Time-shares the single board LED among `NUM_REQ` requesters, each asking for a burst of N blinks. A free-running prescaler creates a slow tick. A round-robin arbiter picks the next requester. An FSM sequences the ON/OFF/GAP phases in tick units. It sits between status sources (heartbeat, error flags, user logic) and the `led` pin of the iCE40 top level.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `COUNT_W`, 4: width of each blink-count request.
- `PRESCALE_W`, 22: prescaler width; one tick every 2^PRESCALE_W cycles.
- `ON_TICKS`, 2: ticks LED is on per blink (>=1).
- `OFF_TICKS`, 2: ticks LED is off between blinks (>=1).
- `GAP_TICKS`, 8: ticks of dark after the last blink before release (>=1).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester request level.
- `req_count`  in  NUM_REQ*COUNT_W  blink count for requester i in bits [i*COUNT_W +: COUNT_W].
- `grant`  out  NUM_REQ  one-hot; high for requester being served, else 0.
- `done`  out  NUM_REQ  one-cycle pulse on completion of requester i's burst.
- `busy`  out  1  high whenever state != IDLE.
- `tick`  out  1  prescaler tick (debug/observability).
- `led`  out  1  LED drive, active high.

## Operation
- Reset (async, `reset_n`=0) clears: prescaler=0, state=IDLE, the remaining-blinks and phase counters, and the RR pointer (index 0 has top priority). Outputs `led`, `grant`, `done`, `busy`, `tick` are all 0.
- Prescaler: PRESCALE_W-bit up-counter, wraps freely and never stops. `tick` = (prescaler == all ones), combinational from the register.
- Arbitration (IDLE only): choose the first i with `req[i]`=1, scanning from the RR pointer upward and wrapping. The latched count = `req_count` slice i, sampled only in this cycle. The pointer becomes i+1 (mod NUM_REQ) when that requester reaches DONE.
- States:
  - IDLE: `led`=0. Any req goes to ON, or to DONE if the latched count is 0. Phase=0. Register the grant.
  - ON: `led`=1. On each tick, phase++. When a tick lands at phase==ON_TICKS-1, go to OFF with phase=0.
  - OFF: `led`=0. Counts OFF_TICKS ticks, then decrements remaining. If remaining is now 0, go to GAP, else ON.
  - GAP: `led`=0. Counts GAP_TICKS ticks, then DONE.
  - DONE: single cycle. `done[i]`=1, grant still high. Next state is IDLE, where grant=0.
- `grant` stays stable from the cycle after selection through DONE inclusive.
- Dropping `req[i]` mid-service is ignored. The burst always completes.
- A requester still holding `req` after `done` is re-eligible, but only after all other active requesters are served (round-robin).
- Count arithmetic: remaining is COUNT_W bits and never wraps. The maximum burst is 2^COUNT_W-1 blinks.

## Timing
- `req` seen in IDLE at edge k: `grant`, `busy` and `led` (if count>0) go high after edge k. Latency is 1 cycle.
- Phases are tick-aligned, so the first ON phase is partial: it lasts between (ON_TICKS-1)*2^P+1 and ON_TICKS*2^P cycles. All later OFF/ON/GAP phases are exactly N*2^P cycles.
- DONE to next grant: at least one IDLE cycle; `busy` drops for exactly 1 cycle when back-to-back.
- Tick coinciding with the grant edge does not count toward ON.
- A count of 0 gives: grant high for 2 cycles (IDLE to DONE, then DONE), `done` pulse in the second, `led` never high.
- Reset asserted mid-burst forces `led`=0 and `grant`=0 immediately, without waiting for a clock. No `done` is produced.

## Test plan
Run with PRESCALE_W=2 (tick every 4 cycles), ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=2, NUM_REQ=4.
- Reset, then idle for 12 cycles: all outputs 0 during reset; `tick` high on cycles 3, 7 and 11 after release; `led`/`busy` stay 0.
- `req[0]`=1 with count=2: `grant`=0001 next cycle, `led` high, then two 4-cycle blinks, an 8-cycle gap, a single `done[0]` pulse, and `grant`=0000.
- `req[0]` and `req[2]` held from reset, counts 1: served in order 0, 2, 0, 2 with one IDLE cycle between each burst, and `busy` low for exactly 1 cycle each time.
- `req[3]` with count=0: `grant`=1000 for 2 cycles, `done[3]` in the second, `led` stays 0.
- `req[1]` count=3, `req[1]` dropped after 2 cycles: all 3 blinks still occur and `done[1]` pulses.
- `reset_n` pulsed low mid-ON: `led`/`grant` go 0 without waiting for a clock, no `done`. After release, with `req[1]` and `req[0]` both high, `grant`=0001 (pointer reset).
